cover_sched: RTL and testbench
==============================

// Module: cover_sched
// PURPOSE
// - Round-robin scheduler sharing one coverage-evaluation datapath (LANES
//   is_covered instances + point bank) among NREQ requesters.
// - Each request is a candidate centre (cx,cy). The block steps the point
//   bank through NPTS/LANES groups and accumulates the covered-and-valid hits.
// - Returns the hit count to the winning requester.
// - Sits between the candidate-search engines and the point storage/evaluator array.
// PARAMETERS
// - NPTS   40  total points held in the point bank
// - LANES  8   evaluator lanes per cycle; NPTS % LANES == 0 required
// - NREQ   2   number of requesters (>=2)
// PORTS
// - CLK      in   1         clock; all state updates on posedge
// - RST      in   1         asynchronous, active-high reset
// - REQ_VLD  in   NREQ      per-requester request valid
// - REQ_CX   in   4*NREQ    centre x, requester k at [4k+3:4k]
// - REQ_CY   in   4*NREQ    centre y, same packing
// - REQ_RDY  out  NREQ      one-hot accept strobe
// - CV_CX    out  4         centre x driven to the evaluator array
// - CV_CY    out  4         centre y driven to the evaluator array
// - GRP      out  3         point-group select; group g = points [g*LANES +: LANES]
// - CV_HIT   in   LANES     covered & is_valid per lane, combinational from CV_*/GRP
// - RSP_VLD  out  1         response valid
// - RSP_ID   out  clog2(NREQ)  index of the requester being answered
// - RSP_CNT  out  clog2(NPTS+1) covered-point count (6 b at default)
// - RSP_CX   out  4         echoed centre x
// - RSP_CY   out  4         echoed centre y
// - RSP_RDY  in   1         response consumed
// - BUSY     out  1         high in EVAL or RESP
// BEHAVIOUR
// - Reset values: all outputs 0; state IDLE; rr_ptr=0; acc=0; beat=0.
// - FSM: IDLE -> EVAL -> RESP -> IDLE.
// - IDLE:
//   - The winner is the first k with REQ_VLD[k], searching from rr_ptr upward with wrap.
//   - REQ_RDY[winner]=1 in the same cycle (combinational); all other bits 0.
//   - On the clock edge: latch cx, cy and id; acc=0; beat=0; go to EVAL.
//   - If no request: stay in IDLE; REQ_RDY=0.
//   - CV_CX, CV_CY and GRP are 0 in IDLE.
// - EVAL:
//   - CV_CX/CV_CY = latched centre; GRP = beat.
//   - acc += popcount(CV_HIT) on every EVAL cycle.
//   - beat increments 0..NPTS/LANES-1 and never exceeds BEATS-1.
//   - Leaving EVAL: after beat==BEATS-1, move to RESP with the final acc.
// - RESP:
//   - RSP_VLD=1; RSP_ID, RSP_CNT, RSP_CX and RSP_CY are held stable until RSP_RDY.
//   - On RSP_VLD & RSP_RDY: rr_ptr = (id+1) mod NREQ; go to IDLE.
//   - REQ_RDY=0 throughout RESP.
// - Latency:
//   - Accept at cycle T; EVAL occupies T+1..T+BEATS.
//   - RSP_VLD first high at T+BEATS+1 (T+6 at default).
//   - Minimum request-to-request period is BEATS+2 cycles.
// - Width: acc is clog2(NPTS+1) bits; the maximum value NPTS fits, so no saturation is needed.
// - Boundaries:
//   - A requester may drop REQ_VLD before acceptance; no side effects.
//   - RSP_RDY without RSP_VLD is ignored.
//   - CV_HIT is ignored outside EVAL.
//   - Simultaneous requests are resolved by rr_ptr only, so the arbiter is starvation-free.
//   - A new request for the same requester is arbitrated normally after its response.
//   - RST mid-EVAL/RESP aborts the operation with no response; the next accept uses rr_ptr=0.
//   - Point-bank contents changing during EVAL are not this block's concern.
// STRUCTURE
// - Shared package cover_pkg:
//   - NPTS, LANES, BEATS=NPTS/LANES
//   - CNT_W=clog2(NPTS+1)
//   - state enum {IDLE, EVAL, RESP}
// - Sub-module hit_popcount: LANES-bit popcount, purely combinational.
// - Arbiter, FSM, beat counter and accumulator live in cover_sched.
// TESTING
// - Single request:
//   - Stimulus: REQ_VLD=01, centre (5,7); CV_HIT model gives 3,0,8,1,2 hits over GRP 0..4.
//   - Required: RSP_CNT=14, RSP_ID=0, echo (5,7), RSP_VLD at T+6.
// - Contention:
//   - Stimulus: REQ_VLD=11 held from reset.
//   - Required: req0 is served first, then req1, then req0 again (alternating).
//   - Required: REQ_RDY is always one-hot.
// - Backpressure:
//   - Stimulus: RSP_RDY=0 for 10 cycles.
//   - Required: RSP_* stable, BUSY=1, REQ_RDY=0; IDLE one cycle after RSP_RDY=1.
// - Full coverage:
//   - Stimulus: CV_HIT=8'hFF in all beats.
//   - Required: RSP_CNT=40; GRP sequence is exactly 0,1,2,3,4.
// - Reset mid-EVAL:
//   - Stimulus: RST pulse at beat 2.
//   - Required: all outputs 0; no RSP_VLD; next REQ_VLD=11 grants req0.
// - Withdrawn request:
//   - Stimulus: REQ_VLD[1] pulses high while busy and drops before IDLE.
//   - Required: it is never granted; no response with RSP_ID=1.

Source files
------------

// File: rtl/cover_pkg.sv
// cover_pkg: shared sizing and state encoding for the coverage scheduler
package cover_pkg;
  localparam int NPTS = 40;
  localparam int LANES = 8;
  localparam int BEATS = NPTS / LANES;
  localparam int CNT_W = $clog2(NPTS + 1);
  localparam int GRP_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;
endpackage

// File: rtl/hit_popcount.sv
// hit_popcount: combinational count of set lanes in one evaluator beat
module hit_popcount
  import cover_pkg::*;
(
  input  logic [LANES-1:0] hit_i,
  output logic [CNT_W-1:0] cnt_o
);
  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < LANES; i++) cnt_o = cnt_o + CNT_W'(hit_i[i]);
  end
endmodule

// File: rtl/cover_sched.sv
// cover_sched: round-robin sharing of the coverage evaluator among requesters,
// stepping the point bank group by group and returning the hit count.
module cover_sched
  import cover_pkg::*;
#(
  parameter int NREQ = 2,
  localparam int ID_W = $clog2(NREQ)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NREQ-1:0]   req_vld_i,
  input  logic [4*NREQ-1:0] req_cx_i,
  input  logic [4*NREQ-1:0] req_cy_i,
  output logic [NREQ-1:0]   req_rdy_o,
  output logic [3:0]        cv_cx_o,
  output logic [3:0]        cv_cy_o,
  output logic [GRP_W-1:0]  grp_o,
  input  logic [LANES-1:0]  cv_hit_i,
  output logic              rsp_vld_o,
  output logic [ID_W-1:0]   rsp_id_o,
  output logic [CNT_W-1:0]  rsp_cnt_o,
  output logic [3:0]        rsp_cx_o,
  output logic [3:0]        rsp_cy_o,
  input  logic              rsp_rdy_i,
  output logic              busy_o
);
  state_t             state_q;
  logic [ID_W-1:0]    rr_q, id_q, win;
  logic [3:0]         cx_q, cy_q;
  logic [CNT_W-1:0]   acc_q, acc_d, pop;
  logic [GRP_W-1:0]   beat_q;
  logic               any_req, last_beat;

  hit_popcount u_pop (.hit_i(cv_hit_i), .cnt_o(pop));

  function automatic logic [ID_W-1:0] rot(input logic [ID_W-1:0] base, input int off);
    int j;
    j = int'(base) + off;
    return ID_W'(j >= NREQ ? j - NREQ : j);
  endfunction

  // Walk offsets from farthest to nearest so the one closest to rr_q wins.
  always_comb begin
    win = '0;
    for (int i = NREQ - 1; i >= 0; i--) win = req_vld_i[rot(rr_q, i)] ? rot(rr_q, i) : win;
  end

  assign any_req   = |req_vld_i;
  assign last_beat = beat_q == GRP_W'(BEATS - 1);
  assign acc_d     = acc_q + pop;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rr_q    <= '0;
      id_q    <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      acc_q   <= '0;
      beat_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (any_req) begin
          id_q    <= win;
          cx_q    <= req_cx_i[4*win +: 4];
          cy_q    <= req_cy_i[4*win +: 4];
          acc_q   <= '0;
          beat_q  <= '0;
          state_q <= EVAL;
        end
        EVAL: begin
          acc_q   <= acc_d;
          beat_q  <= last_beat ? beat_q : beat_q + 1'b1;
          state_q <= last_beat ? RESP : EVAL;
        end
        RESP: if (rsp_rdy_i) begin
          rr_q    <= (id_q == ID_W'(NREQ - 1)) ? '0 : id_q + 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_rdy_o = (state_q == IDLE && any_req) ? {{(NREQ-1){1'b0}}, 1'b1} << win : '0;
  assign cv_cx_o   = state_q == EVAL ? cx_q : '0;
  assign cv_cy_o   = state_q == EVAL ? cy_q : '0;
  assign grp_o     = state_q == EVAL ? beat_q : '0;
  assign rsp_vld_o = state_q == RESP;
  assign rsp_id_o  = rsp_vld_o ? id_q : '0;
  assign rsp_cnt_o = rsp_vld_o ? acc_q : '0;
  assign rsp_cx_o  = rsp_vld_o ? cx_q : '0;
  assign rsp_cy_o  = rsp_vld_o ? cy_q : '0;
  assign busy_o    = state_q != IDLE;
endmodule

// File: tb/tb_cover_sched.sv
// tb_cover_sched: directed and randomized checks of cover_sched against a
// transaction-level model of arbitration, latency and hit counting.
module tb_cover_sched;
  import cover_pkg::*;
  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] req_vld, req_rdy;
  logic [7:0] req_cx, req_cy;
  logic [3:0] cv_cx, cv_cy, rsp_cx, rsp_cy;
  logic [GRP_W-1:0] grp;
  logic [LANES-1:0] cv_hit;
  logic rsp_vld, rsp_rdy, busy;
  logic [0:0] rsp_id;
  logic [CNT_W-1:0] rsp_cnt;
  logic [7:0] tab [BEATS];
  int n_chk = 0, n_fail = 0, rr_m = 0;

  always #5 clk = ~clk;
  always_comb cv_hit = (int'(grp) < BEATS) ? tab[grp] : 8'hxx;

  cover_sched #(.NREQ(2)) dut (
    .clk_i(clk), .rst_i(rst), .req_vld_i(req_vld), .req_cx_i(req_cx), .req_cy_i(req_cy),
    .req_rdy_o(req_rdy), .cv_cx_o(cv_cx), .cv_cy_o(cv_cy), .grp_o(grp), .cv_hit_i(cv_hit),
    .rsp_vld_o(rsp_vld), .rsp_id_o(rsp_id), .rsp_cnt_o(rsp_cnt), .rsp_cx_o(rsp_cx),
    .rsp_cy_o(rsp_cy), .rsp_rdy_i(rsp_rdy), .busy_o(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({req_rdy, cv_cx, cv_cy, grp, rsp_vld, rsp_id, rsp_cnt, rsp_cx, rsp_cy, busy});
  endfunction

  task automatic xact(input logic [1:0] vld, input logic [3:0] cx0, cy0, cx1, cy1,
                      input logic [1:0] vld_eval, input logic keep, input int delay,
                      input logic early);
    int w, ecnt;
    logic [3:0] ecx, ecy;
    req_vld = vld; req_cx = {cx1, cx0}; req_cy = {cy1, cy0}; rsp_rdy = 1'b0;
    #1;
    w = -1;
    for (int i = 0; i < 2; i++) if (w < 0 && vld[(rr_m + i) % 2]) w = (rr_m + i) % 2;
    chk("req_rdy_grant", 32'(req_rdy), w < 0 ? 32'd0 : 32'd1 << w);
    if (w < 0) begin
      @(negedge clk);
      chk("idle_busy", 32'(busy), 32'd0);
      return;
    end
    ecx = w ? cx1 : cx0; ecy = w ? cy1 : cy0;
    ecnt = 0;
    for (int g = 0; g < BEATS; g++) ecnt += $countones(tab[g]);
    @(negedge clk);
    req_vld = vld_eval; rsp_rdy = early;
    for (int b = 0; b < BEATS; b++) begin
      chk("eval_grp", 32'(grp), 32'(b));
      chk("eval_centre", 32'({cv_cx, cv_cy}), 32'({ecx, ecy}));
      chk("eval_flags", 32'({busy, rsp_vld, req_rdy}), 32'b1000);
      @(negedge clk);
    end
    req_vld = keep ? vld_eval : 2'b00;
    chk("rsp_fields", 32'({rsp_vld, rsp_id, rsp_cnt, rsp_cx, rsp_cy}),
        32'({1'b1, 1'(w), CNT_W'(ecnt), ecx, ecy}));
    rsp_rdy = delay == 0;
    for (int d = 0; d < delay; d++) begin
      @(negedge clk);
      chk("rsp_hold", 32'({busy, req_rdy, rsp_vld, rsp_id, rsp_cnt, rsp_cx, rsp_cy}),
          32'({1'b1, 2'b00, 1'b1, 1'(w), CNT_W'(ecnt), ecx, ecy}));
      if (d == delay - 1) rsp_rdy = 1'b1;
    end
    @(negedge clk);
    chk("back_idle", 32'({busy, rsp_vld}), 32'd0);
    rr_m = (w + 1) % 2;
    rsp_rdy = 1'b0;
    req_vld = 2'b00;
  endtask

  initial begin
    req_vld = 0; req_cx = 0; req_cy = 0; rsp_rdy = 1'b1;
    tab = '{default: 8'hFF};
    #2 chk("reset_outs", all_outs(), 32'd0);
    @(negedge clk); rst = 1'b0; rsp_rdy = 1'b0;
    // contention from reset: alternating grants starting at req0
    tab = '{8'h11, 8'h22, 8'h44, 8'h88, 8'hF0};
    xact(2'b11, 4'd1, 4'd2, 4'd3, 4'd4, 2'b11, 1'b1, 0, 1'b0);
    xact(2'b11, 4'd1, 4'd2, 4'd3, 4'd4, 2'b11, 1'b1, 0, 1'b0);
    xact(2'b11, 4'd1, 4'd2, 4'd3, 4'd4, 2'b11, 1'b1, 0, 1'b0);
    // single request, hits 3,0,8,1,2
    tab = '{8'h07, 8'h00, 8'hFF, 8'h01, 8'h03};
    xact(2'b01, 4'd5, 4'd7, 4'd0, 4'd0, 2'b00, 1'b0, 0, 1'b0);
    // backpressure
    xact(2'b01, 4'd9, 4'd3, 4'd0, 4'd0, 2'b00, 1'b0, 10, 1'b0);
    // full coverage
    tab = '{default: 8'hFF};
    xact(2'b01, 4'd15, 4'd15, 4'd0, 4'd0, 2'b00, 1'b0, 0, 1'b1);
    // reset mid-EVAL at beat 2
    req_vld = 2'b10; req_cx = 8'hA0; req_cy = 8'hB0;
    #1 chk("rst_pre_grant", 32'(req_rdy), 32'b10);
    @(negedge clk); req_vld = 2'b00;
    @(negedge clk);
    @(negedge clk);
    chk("rst_pre_grp", 32'(grp), 32'd2);
    rst = 1'b1;
    #1 chk("rst_mid_outs", all_outs(), 32'd0);
    @(negedge clk); rst = 1'b0; rr_m = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("rst_no_rsp", 32'({rsp_vld, busy}), 32'd0);
    end
    xact(2'b11, 4'd2, 4'd2, 4'd6, 4'd6, 2'b00, 1'b0, 1, 1'b0);
    // withdrawn request from requester 1 while busy
    xact(2'b01, 4'd4, 4'd4, 4'd8, 4'd8, 2'b10, 1'b0, 2, 1'b0);
    xact(2'b00, 4'd0, 4'd0, 4'd0, 4'd0, 2'b00, 1'b0, 0, 1'b0);
    // randomized transactions
    for (int t = 0; t < 30; t++) begin
      for (int g = 0; g < BEATS; g++) tab[g] = 8'($urandom);
      xact(2'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
           2'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
